ov_dvp_tx: RTL
==============

# ov_dvp_tx

Transmits a stored RGB565 frame as an 8-bit DVP camera stream with the same `vsync`/`href`/byte polarity that our OV2640 capture path consumes. The block reads pixels from a frame-buffer RAM port and serialises each 16-bit pixel as two bytes, high byte first. It sits between the frame-buffer BRAM and either a loop-back into the capture block for self-test, or an external DVP sink.

## Interface
Parameters:
- `H_ACTIVE`, 320, pixels per line.
- `V_ACTIVE`, 240, lines per frame.
- `H_BLANK`, 16, `pclk` cycles with `href` low between lines.
- `VS_LEAD`, 8, cycles with `vsync` high before the first `href`.
- `VS_TAIL`, 8, cycles with `vsync` high after the last line's blank.
- `VS_LOW`, 32, minimum cycles with `vsync` low between frames.

Ports:
- `pclk`  in  1  single clock, rising edge.
- `rst`  in  1  synchronous reset, active-high.
- `enable`  in  1  level; frames are sent while high.
- `rd_en`  out  1  frame-buffer read strobe.
- `rd_addr`  out  17  linear pixel address, 0..H_ACTIVE*V_ACTIVE-1.
- `rd_data`  in  16  RGB565 read data, valid exactly 1 cycle after `rd_en`.
- `vsync`  out  1  high for the whole frame.
- `href`  out  1  high while active bytes are on `d`.
- `d`  out  8  pixel byte.
- `busy`  out  1  high in every state except IDLE.
- `frame_done`  out  1  one-cycle pulse on entry to FRAME_GAP.

## Operation
- FSM states:
  - IDLE: all outputs low. Goes to LEAD when `enable`=1.
  - LEAD: `vsync`=1 for VS_LEAD cycles, then LINE.
  - LINE: `href`=1 for 2*H_ACTIVE cycles, then HBLANK.
  - HBLANK: `href`=0 for H_BLANK cycles. Then LINE if more lines remain, otherwise TAIL.
  - TAIL: `vsync`=1 for VS_TAIL cycles, then FRAME_GAP.
  - FRAME_GAP: `vsync`=0 for VS_LOW cycles. Then LEAD if `enable`=1, else IDLE.
- Byte order: even byte index in a line is `rd_data[15:8]`, odd index is `rd_data[7:0]`. This lets the capture block's `{first,second}` reconstruction return the original pixel.
- Addressing:
  - `rd_addr` starts at 0 on every frame start and increments once per pixel.
  - It is never issued at or beyond H_ACTIVE*V_ACTIVE.
  - It is reset to 0 on FRAME_GAP entry.
- `enable` falling mid-frame does not truncate the frame; the block finishes through FRAME_GAP and then goes to IDLE. The sink never sees a partial frame.
- Counters:
  - Cycle counter: 16 bits. Line counter: 9 bits. Byte counter: 10 bits.
  - Parameters must fit these widths; out-of-range values are a config error and have no defined behaviour.

## Timing
- Reset values: `vsync`=0, `href`=0, `d`=0, `rd_en`=0, `rd_addr`=0, `busy`=0, `frame_done`=0.
- `rst` asserted mid-frame forces all reset values on the next edge with no tail. State is IDLE.
- All outputs are registered; `d`, `href` and `vsync` change only on the rising edge of `pclk`.
- Read latency:
  - `rd_en` is high for 1 cycle, 2 cycles before the high byte of a pixel appears on `d`.
  - `rd_data` is captured into a 16-bit holding register 1 cycle after `rd_en`.
  - The high byte drives `d` on the next cycle, and the low byte on the cycle after that.
- Read rate: `rd_en` duty is exactly 1 in 2 during LINE. The first read of each line is issued in the last 2 cycles of the preceding LEAD or HBLANK.
- `d` holds 0 whenever `href`=0.
- `vsync` rises on the first LEAD cycle and falls on the first FRAME_GAP cycle. `frame_done` is asserted in that same FRAME_GAP-entry cycle.
- Frame period: VS_LEAD + V_ACTIVE*(2*H_ACTIVE+H_BLANK) + VS_TAIL + VS_LOW cycles, identical for every back-to-back frame.

## Structure
- Package `ov_dvp_pkg` holds:
  - the state enum (IDLE, LEAD, LINE, HBLANK, TAIL, FRAME_GAP);
  - default geometry constants 320/240;
  - the frame-size constant 76800;
  - the address width of 17.
- Sub-module `dvp_timing_gen` generates `vsync`/`href`, the byte index and the line index from the FSM. The top level adds read prefetch, the holding register and byte muxing.

## Test plan
- Small geometry (H_ACTIVE=4, V_ACTIVE=3, H_BLANK=2, VS_LEAD=VS_TAIL=2, VS_LOW=4), RAM word = address+0x1000 → `d` sequence 10,00,10,01,10,02,10,03 on line 0; `href` high 8 cycles per line, 3 lines.
- Same setup, `rd_addr` monitor → addresses 0..11 each exactly once, never 12; `frame_done` pulses once per frame.
- Loop-back into the capture block at 320x240 → RAM contents after one frame equal the source buffer word-for-word, 76800 writes.
- `enable` held high for 3 frames → `vsync` period constant at the computed frame-period value, `vsync` low exactly VS_LOW cycles between frames.
- `enable` dropped during line 1 → frame completes all V_ACTIVE lines, then the block goes to IDLE with `busy`=0.
- `rst` pulsed during LINE → next cycle all outputs 0; after release with `enable`=1, the frame restarts from `rd_addr`=0.

Source files
------------

// File: rtl/ov_dvp_pkg.sv
// rtl/ov_dvp_pkg.sv - shared types and geometry constants for the DVP transmitter
package ov_dvp_pkg;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_LEAD,
        ST_LINE,
        ST_HBLANK,
        ST_TAIL,
        ST_FRAME_GAP
    } dvp_state_t;

    localparam int DEF_H_ACTIVE = 320;
    localparam int DEF_V_ACTIVE = 240;
    localparam int FRAME_PIXELS = 76800;
    localparam int ADDR_W       = 17;

endpackage

// File: rtl/dvp_timing_gen.sv
// rtl/dvp_timing_gen.sv - frame FSM producing vsync/href plus byte and line indices
module dvp_timing_gen
    import ov_dvp_pkg::*;
#(
    parameter int H_ACTIVE = DEF_H_ACTIVE,
    parameter int V_ACTIVE = DEF_V_ACTIVE,
    parameter int H_BLANK  = 16,
    parameter int VS_LEAD  = 8,
    parameter int VS_TAIL  = 8,
    parameter int VS_LOW   = 32
) (
    input  logic        pclk,
    input  logic        rst,
    input  logic        enable,
    output dvp_state_t  state_nxt,
    output logic [15:0] cnt_nxt,
    output logic [9:0]  byte_idx,
    output logic [8:0]  line_idx,
    output logic        vsync,
    output logic        href,
    output logic        busy,
    output logic        frame_done
);

    localparam logic [15:0] LEAD_LAST = 16'(VS_LEAD - 1);
    localparam logic [15:0] LINE_LAST = 16'(2 * H_ACTIVE - 1);
    localparam logic [15:0] HB_LAST   = 16'(H_BLANK - 1);
    localparam logic [15:0] TAIL_LAST = 16'(VS_TAIL - 1);
    localparam logic [15:0] LOW_LAST  = 16'(VS_LOW - 1);
    localparam logic [8:0]  LAST_LINE = 9'(V_ACTIVE - 1);

    dvp_state_t  state_q;
    logic [15:0] cnt_q;
    logic [8:0]  line_q;
    logic [8:0]  line_nxt;
    logic        vsync_d, href_d, busy_d, frame_done_d;

    always_ff @(posedge pclk) begin
        if (rst) begin
            state_q    <= ST_IDLE;
            cnt_q      <= '0;
            line_q     <= '0;
            vsync      <= 1'b0;
            href       <= 1'b0;
            busy       <= 1'b0;
            frame_done <= 1'b0;
        end else begin
            state_q    <= state_nxt;
            cnt_q      <= cnt_nxt;
            line_q     <= line_nxt;
            vsync      <= vsync_d;
            href       <= href_d;
            busy       <= busy_d;
            frame_done <= frame_done_d;
        end
    end

    always_comb begin
        state_nxt = state_q;
        case (state_q)
            ST_IDLE:      if (enable) state_nxt = ST_LEAD;
            ST_LEAD:      if (cnt_q == LEAD_LAST) state_nxt = ST_LINE;
            ST_LINE:      if (cnt_q == LINE_LAST) state_nxt = ST_HBLANK;
            ST_HBLANK:    if (cnt_q == HB_LAST)
                              state_nxt = (line_q == LAST_LINE) ? ST_TAIL : ST_LINE;
            ST_TAIL:      if (cnt_q == TAIL_LAST) state_nxt = ST_FRAME_GAP;
            ST_FRAME_GAP: if (cnt_q == LOW_LAST)
                              state_nxt = enable ? ST_LEAD : ST_IDLE;
            default:      state_nxt = ST_IDLE;
        endcase

        // Every state starts counting from zero; IDLE never counts.
        if (state_nxt != state_q || state_q == ST_IDLE)
            cnt_nxt = '0;
        else
            cnt_nxt = cnt_q + 16'd1;

        line_nxt = '0;
        if (state_nxt == ST_LINE || state_nxt == ST_HBLANK)
            line_nxt = (state_q == ST_HBLANK && state_nxt == ST_LINE) ? line_q + 9'd1 : line_q;
    end

    always_comb begin
        vsync_d      = (state_nxt == ST_LEAD) || (state_nxt == ST_LINE) ||
                       (state_nxt == ST_HBLANK) || (state_nxt == ST_TAIL);
        href_d       = (state_nxt == ST_LINE);
        busy_d       = (state_nxt != ST_IDLE);
        frame_done_d = (state_nxt == ST_FRAME_GAP) && (state_q != ST_FRAME_GAP);
        byte_idx     = cnt_nxt[9:0];
        line_idx     = line_nxt;
    end

endmodule

// File: rtl/ov_dvp_tx.sv
// rtl/ov_dvp_tx.sv - RGB565 frame-buffer to 8-bit DVP stream transmitter
module ov_dvp_tx
    import ov_dvp_pkg::*;
#(
    parameter int H_ACTIVE = DEF_H_ACTIVE,
    parameter int V_ACTIVE = DEF_V_ACTIVE,
    parameter int H_BLANK  = 16,
    parameter int VS_LEAD  = 8,
    parameter int VS_TAIL  = 8,
    parameter int VS_LOW   = 32
) (
    input  logic              pclk,
    input  logic              rst,
    input  logic              enable,
    output logic              rd_en,
    output logic [ADDR_W-1:0] rd_addr,
    input  logic [15:0]       rd_data,
    output logic              vsync,
    output logic              href,
    output logic [7:0]        d,
    output logic              busy,
    output logic              frame_done
);

    localparam logic [15:0]       LEAD_PF      = 16'(VS_LEAD - 2);
    localparam logic [15:0]       HB_PF        = 16'(H_BLANK - 2);
    localparam logic [9:0]        LINE_PF_LAST = 10'(2 * H_ACTIVE - 4);
    localparam logic [8:0]        LAST_LINE    = 9'(V_ACTIVE - 1);
    localparam logic [ADDR_W-1:0] LAST_ADDR    = ADDR_W'(H_ACTIVE * V_ACTIVE - 1);

    dvp_state_t        state_nxt;
    logic [15:0]       cnt_nxt;
    logic [9:0]        byte_idx;
    logic [8:0]        line_idx;
    logic [15:0]       hold;
    logic [15:0]       pix;
    logic              fetch, load;
    logic [7:0]        d_d;
    logic [ADDR_W-1:0] addr_d;

    dvp_timing_gen #(
        .H_ACTIVE (H_ACTIVE),
        .V_ACTIVE (V_ACTIVE),
        .H_BLANK  (H_BLANK),
        .VS_LEAD  (VS_LEAD),
        .VS_TAIL  (VS_TAIL),
        .VS_LOW   (VS_LOW)
    ) u_timing (
        .pclk       (pclk),
        .rst        (rst),
        .enable     (enable),
        .state_nxt  (state_nxt),
        .cnt_nxt    (cnt_nxt),
        .byte_idx   (byte_idx),
        .line_idx   (line_idx),
        .vsync      (vsync),
        .href       (href),
        .busy       (busy),
        .frame_done (frame_done)
    );

    // A read issued two cycles ahead of each even byte; the first of a line
    // falls in the second-to-last cycle of LEAD or HBLANK.
    always_comb begin
        fetch = ((state_nxt == ST_LEAD) && (cnt_nxt == LEAD_PF)) ||
                ((state_nxt == ST_HBLANK) && (cnt_nxt == HB_PF) && (line_idx != LAST_LINE)) ||
                ((state_nxt == ST_LINE) && !byte_idx[0] && (byte_idx <= LINE_PF_LAST));
        load  = (state_nxt == ST_LINE) && !byte_idx[0];
        pix   = load ? rd_data : hold;
        d_d   = 8'h00;
        if (state_nxt == ST_LINE)
            d_d = byte_idx[0] ? pix[7:0] : pix[15:8];

        addr_d = rd_addr;
        if (state_nxt == ST_FRAME_GAP || state_nxt == ST_IDLE)
            addr_d = '0;
        else if (rd_en && rd_addr != LAST_ADDR)
            addr_d = rd_addr + 1'b1;
    end

    always_ff @(posedge pclk) begin
        if (rst) begin
            rd_en   <= 1'b0;
            rd_addr <= '0;
            hold    <= '0;
            d       <= '0;
        end else begin
            rd_en   <= fetch;
            rd_addr <= addr_d;
            hold    <= pix;
            d       <= d_d;
        end
    end

endmodule
